// File: rtl/alu4_banked.sv
// alu4_banked: banked 4-bit logic/arithmetic ALU with registered result and NZVC flags; result pin is tri-stated by an active-low enable
module alu4_banked #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       ALUop,
  input  logic             Cin,
  input  logic             enable,
  input  logic             ALUbank,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);
  logic [WIDTH-1:0] x, y, lres, r_n, res_q;
  logic [WIDTH:0]   sum;
  logic             ci, v_n, c_n;
  logic             is_shift;
  always_comb begin
    lres = '0;
    case (ALUop)
      3'd1: lres = A;
      3'd2: lres = B;
      3'd3: lres = ~A;
      3'd4: lres = ~B;
      3'd5: lres = A & B;
      3'd6: lres = A | B;
      3'd7: lres = A ^ B;
      default: lres = '0;
    endcase
  end
  // Adder operands; V is judged on these actual inputs so subtracts share the add rule.
  always_comb begin
    x = A;
    y = B;
    ci = 1'b0;
    case (ALUop)
      3'd0: ci = Cin;
      3'd1: begin y = ~B; ci = Cin; end
      3'd2: begin y = '0; ci = 1'b1; end
      3'd3: y = '1;
      3'd5: begin y = ~B; ci = 1'b1; end
      3'd6: begin x = B; y = ~A; ci = 1'b1; end
      default: ;
    endcase
  end
  assign sum = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, ci};
  assign is_shift = ALUop == 3'd7;
  assign r_n = !ALUbank ? lres : is_shift ? {A[WIDTH-2:0], Cin} : sum[WIDTH-1:0];
  assign c_n = ALUbank && (is_shift ? A[WIDTH-1] : sum[WIDTH]);
  assign v_n = ALUbank && (is_shift ? A[WIDTH-1] ^ A[WIDTH-2]
                                    : (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      flags <= '0;
    end else begin
      res_q <= r_n;
      flags <= {r_n[WIDTH-1], r_n == '0, v_n, c_n};
    end
  end
  assign result = enable ? 'z : res_q;
endmodule

// File: tb/tb_alu4_banked.sv
// tb_alu4_banked: directed vectors with a queue scoreboard checked by an independent monitor
module tb_alu4_banked;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] A = 4'd0, B = 4'd0;
  logic [2:0] ALUop = 3'd0;
  logic       Cin = 1'b0, enable = 1'b0, ALUbank = 1'b0;
  logic [3:0] result, flags;
  int checks = 0, errors = 0;

  typedef struct {
    logic [3:0] r;
    logic [3:0] f;
    string      name;
  } exp_t;
  exp_t q[$];

  alu4_banked dut (
    .clock(clock), .reset(reset), .A(A), .B(B), .ALUop(ALUop), .Cin(Cin),
    .enable(enable), .ALUbank(ALUbank), .result(result), .flags(flags)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    #2;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (result !== e.r || flags !== e.f) begin
        errors++;
        $display("FAIL %s: got result=%b flags=%b, expected result=%b flags=%b",
                 e.name, result, flags, e.r, e.f);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic issue(input string name, input logic bank, input logic [2:0] op,
                       input logic [3:0] a, input logic [3:0] b, input logic cin,
                       input logic [3:0] er, input logic [3:0] ef);
    exp_t e;
    @(negedge clock);
    #1;
    ALUbank = bank; ALUop = op; A = a; B = b; Cin = cin;
    e.r = er; e.f = ef; e.name = name;
    q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    A = 4'd7; B = 4'd1; ALUbank = 1'b1; ALUop = 3'd0;
    #2;
    check("reset_result", result, 4'b0000);
    check("reset_flags", flags, 4'b0000);
    @(posedge clock);
    #2;
    check("reset_hold_result", result, 4'b0000);
    check("reset_hold_flags", flags, 4'b0000);
    @(negedge clock);
    reset = 1'b0;
    issue("add_0_1", 1, 3'd0, 4'h0, 4'h1, 0, 4'b0001, 4'b0000);
    issue("add_7_1_ovf", 1, 3'd0, 4'h7, 4'h1, 0, 4'b1000, 4'b1010);
    drain();
    @(posedge clock);
    #3;
    enable = 1'b1;
    #1;
    checks++;
    if (result === 4'b1000) begin
      errors++;
      $display("FAIL oe_release: got %b, expected bus released", result);
    end
    check("oe_flags", flags, 4'b1010);
    enable = 1'b0;
    #1;
    check("oe_restore", result, 4'b1000);
    issue("add_f_1_carry", 1, 3'd0, 4'hF, 4'h1, 0, 4'b0000, 4'b0101);
    issue("add_f_1_cin", 1, 3'd0, 4'hF, 4'h1, 1, 4'b0001, 4'b0001);
    issue("sub_3_5", 1, 3'd5, 4'h3, 4'h5, 0, 4'b1110, 4'b1000);
    issue("sub_3_5_cin_ign", 1, 3'd5, 4'h3, 4'h5, 1, 4'b1110, 4'b1000);
    issue("sub_8_1_ovf", 1, 3'd5, 4'h8, 4'h1, 0, 4'b0111, 4'b0011);
    issue("dec_0", 1, 3'd3, 4'h0, 4'h0, 0, 4'b1111, 4'b1000);
    issue("dec_8", 1, 3'd3, 4'h8, 4'h0, 0, 4'b0111, 4'b0011);
    issue("inc_7", 1, 3'd2, 4'h7, 4'h0, 1, 4'b1000, 4'b1010);
    issue("inc_f", 1, 3'd2, 4'hF, 4'h0, 0, 4'b0000, 4'b0101);
    issue("sbc_5_3_cin1", 1, 3'd1, 4'h5, 4'h3, 1, 4'b0010, 4'b0001);
    issue("sbc_5_3_cin0", 1, 3'd1, 4'h5, 4'h3, 0, 4'b0001, 4'b0001);
    issue("add_9_9_nocin", 1, 3'd4, 4'h9, 4'h9, 1, 4'b0010, 4'b0011);
    issue("rsub_5_3", 1, 3'd6, 4'h5, 4'h3, 0, 4'b1110, 4'b1000);
    issue("logic_op0", 0, 3'd0, 4'b1010, 4'b0110, 1, 4'b0000, 4'b0100);
    issue("logic_op1", 0, 3'd1, 4'b1010, 4'b0110, 0, 4'b1010, 4'b1000);
    issue("logic_op2", 0, 3'd2, 4'b1010, 4'b0110, 0, 4'b0110, 4'b0000);
    issue("logic_op3", 0, 3'd3, 4'b1010, 4'b0110, 0, 4'b0101, 4'b0000);
    issue("logic_op4", 0, 3'd4, 4'b1010, 4'b0110, 0, 4'b1001, 4'b1000);
    issue("logic_op5", 0, 3'd5, 4'b1010, 4'b0110, 0, 4'b0010, 4'b0000);
    issue("logic_op6", 0, 3'd6, 4'b1010, 4'b0110, 0, 4'b1110, 4'b1000);
    issue("logic_op7", 0, 3'd7, 4'b1010, 4'b0110, 1, 4'b1100, 4'b1000);
    issue("shl_9_cin", 1, 3'd7, 4'b1001, 4'b0000, 1, 4'b0011, 4'b0011);
    issue("shl_4", 1, 3'd7, 4'b0100, 4'b0000, 0, 4'b1000, 4'b1010);
    drain();
    @(posedge clock);
    #3;
    reset = 1'b1;
    A = 4'd7; B = 4'd1; ALUbank = 1'b1; ALUop = 3'd0; Cin = 1'b0;
    #1;
    check("midreset_result", result, 4'b0000);
    check("midreset_flags", flags, 4'b0000);
    @(negedge clock);
    reset = 1'b0;
    issue("post_reset_add", 1, 3'd0, 4'h7, 4'h1, 0, 4'b1000, 4'b1010);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu4_banked.md
Name: alu4_banked

Overview:
- 4-bit ALU for the CSC datapath.
- Computes one of 16 operations on operands A and B, selected by a 1-bit bank and a 3-bit opcode, with carry-in.
- Result and NZVC flags are registered on the clock.
- The result output drives a shared data bus through an active-low tri-state enable; the flags feed the CPU's flag/branch logic.

Parameters:
- WIDTH, 4, operand/result width. Only 4 is required to work; the flag definitions assume WIDTH-1 is the sign bit.

Ports:
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high reset
- A  input  4  first operand
- B  input  4  second operand
- ALUop  input  3  operation select within the bank
- Cin  input  1  carry in
- enable  input  1  output enable, active low; 1 puts result in high-Z
- ALUbank  input  1  operation bank select
- result  output  4  registered ALU result, tri-stated
- flags  output  4  registered flags {N,Z,V,C}, always driven

Behaviour:
- Reset (asynchronous, active-high): result register = 0 and flags register = 0 immediately; held while reset=1.
- Each rising clock edge with reset=0: result register <= F(ALUbank,ALUop,A,B,Cin) and flags register <= computed NZVC.
  - Latency is 1 cycle; there is no hold or stall.
- result pin = result register when enable=0; high-Z (4'bzzzz) when enable=1.
- enable is combinational on the pin only and does not affect the registers.
- Operation table, bank 0 (logic; V=0, C=0):
  - op0 = 0
  - op1 = A
  - op2 = B
  - op3 = ~A
  - op4 = ~B
  - op5 = A&B
  - op6 = A|B
  - op7 = A^B
- Operation table, bank 1 (arithmetic; all sums computed 5 bits wide, C = bit 4):
  - op0 = A+B+Cin
  - op1 = A+~B+Cin (subtract with borrow; C=1 means no borrow)
  - op2 = A+1
  - op3 = A+4'hF (A-1)
  - op4 = A+B
  - op5 = A+~B+1 (A-B)
  - op6 = B+~A+1 (B-A)
  - op7 = {A[2:0],Cin} (shift left; C=A[3], V=A[3]^A[2])
- Flags:
  - N = result[3].
  - Z = (result==0).
  - C = 5th bit of the sum as listed above.
  - V for add-type ops = (x[3]==y[3]) && (r[3]!=x[3]), where x,y are the two actual adder inputs (e.g. A and ~B for subtract). Subtract overflow therefore falls out of the same rule.
- Wrap-around: all results truncated to 4 bits; carry out only via C.
- Cin is ignored by every op except bank1 op0, op1 and op7.
- reset asserted mid-operation: registers clear at once; the pending computation is discarded.
- Reset released: the first capture occurs on the next rising edge.
- X/Z on inputs is not required to be handled.

Test Plan:
- Reset: assert reset with A=7, B=1 -> result=0000, flags=0000 without a clock edge. Release reset -> values update on the next edge.
- Add: A=0, B=1, bank1 op0, Cin=0, enable=0 -> after one edge result=0001, flags=0000. Then A=7, B=1 -> result=1000, flags=1010 (N=1, V=1).
- Output enable: with result=1000, set enable=1 -> result=zzzz, flags unchanged at 1010. Set enable=0 -> result=1000 again with no clock edge needed.
- Carry/zero: bank1 op0, A=F, B=1, Cin=0 -> result=0000, flags=0101. Same with Cin=1 -> result=0001, flags=0001.
- Subtract:
  - bank1 op5, A=3, B=5 -> result=1110, flags=1000 (borrow, so C=0).
  - A=8, B=1 -> result=0111, flags=0011.
  - bank1 op3, A=0 -> result=1111, C=0.
- Logic sweep: A=1010, B=0110, bank0 op0-op7 -> 0000, 1010, 0110, 0101, 1001, 0010, 1110, 1100, each with V=C=0. Also check shift: bank1 op7, A=1001, Cin=1 -> result=0011, C=1, V=1.
